// File: rtl/scarv_cop_palu_addsub_seq.sv
// Multi-cycle packed add/subtract for the SCARV COP packed ALU: CW bits per beat, carry chain cut at lane edges.
// Define SCARV_COP_PALU_SAT_EN to add the one-cycle FIX state for unsigned lane saturation.
module scarv_cop_palu_addsub_seq #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic           g_clk,
  input  logic           g_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     lw,
  input  logic           sub,
  input  logic           ci,
  input  logic           sat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   c,
  output logic [W/2-1:0] co_lanes
);

  localparam int NBEAT = W / CW;
  localparam int AW    = $clog2(W);
  localparam int CWL   = $clog2(CW);
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int LNW   = AW - 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [BW-1:0]    beat_q;
  logic             cc_q;
  logic [W-1:0]     a_q, b_q;
  logic [2:0]       lw_q;
  logic             sub_q, ci_q;
  logic [W-1:0]     c_q, c_d;
  logic [W/2-1:0]   co_q, co_d;
  logic             cc_d;
  logic             out_valid_q, in_ready_q;

  int unsigned      lsh;
  logic [AW-1:0]    mask;
  logic [AW-1:0]    idx, nidx;
  logic [LNW-1:0]   lane;
  logic             cy, cin, bx;

  // Lane width clamps to one full-W lane for oversize codes.
  always_comb begin
    lsh = int'(lw_q) + 1;
    if (lsh > AW) lsh = AW;
    mask = (AW'(1) << lsh) - AW'(1);
  end

  // Ripple one chunk; the first bit continues from the chunk-carry register.
  always_comb begin
    c_d  = c_q;
    co_d = co_q;
    cy   = cc_q;
    cin  = 1'b0;
    bx   = 1'b0;
    idx  = '0;
    lane = '0;
    for (int j = 0; j < CW; j++) begin
      idx = (AW'(beat_q) << CWL) | AW'(j);
      if (idx == '0)               cin = sub_q ? 1'b1 : ci_q;
      else if ((idx & mask) == '0) cin = sub_q;
      else                         cin = cy;
      bx       = b_q[idx] ^ sub_q;
      c_d[idx] = a_q[idx] ^ bx ^ cin;
      cy       = (a_q[idx] & bx) | (cin & (a_q[idx] ^ bx));
      if ((idx & mask) == mask) begin
        lane       = LNW'(idx >> lsh);
        co_d[lane] = cy;
      end
    end
    nidx = idx + AW'(1);
    cc_d = ((nidx & mask) == '0) ? 1'b0 : cy;
  end

`ifdef SCARV_COP_PALU_SAT_EN
  logic           sat_q;
  logic [W-1:0]   fix_c;
  logic [AW-1:0]  fidx;
  logic [LNW-1:0] flane;

  // Overflowing lanes clamp: add carry -> all ones, sub borrow -> all zeros.
  always_comb begin
    fix_c = c_q;
    fidx  = '0;
    flane = '0;
    for (int i = 0; i < W; i++) begin
      fidx  = AW'(i);
      flane = LNW'(fidx >> lsh);
      if (sat_q && !sub_q && co_q[flane])     fix_c[i] = 1'b1;
      else if (sat_q && sub_q && !co_q[flane]) fix_c[i] = 1'b0;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      cc_q        <= 1'b0;
      c_q         <= '0;
      co_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            lw_q       <= lw;
            sub_q      <= sub;
            ci_q       <= ci;
`ifdef SCARV_COP_PALU_SAT_EN
            sat_q      <= sat;
`endif
            c_q        <= '0;
            co_q       <= '0;
            cc_q       <= 1'b0;
            beat_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          c_q  <= c_d;
          co_q <= co_d;
          cc_q <= cc_d;
          if (beat_q == LAST_BEAT) begin
`ifdef SCARV_COP_PALU_SAT_EN
            state_q     <= S_FIX;
`else
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
`endif
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        S_FIX: begin
`ifdef SCARV_COP_PALU_SAT_EN
          c_q <= fix_c;
`endif
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign co_lanes  = co_q;

endmodule

// File: tb/tb_scarv_cop_palu_addsub_seq.sv
// Directed bench for scarv_cop_palu_addsub_seq (W=32, CW=8) with hand-computed lane results.
module tb_scarv_cop_palu_addsub_seq;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  lw;
  logic        sub, ci, sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [15:0] co_lanes;

  int total = 0;
  int bad   = 0;
  int lat;

`ifdef SCARV_COP_PALU_SAT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  scarv_cop_palu_addsub_seq #(.W(32), .CW(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .lw(lw), .sub(sub), .ci(ci), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .co_lanes(co_lanes)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] l, input logic s, input logic cin, input logic st,
                        input logic [31:0] av, input logic [31:0] bv);
    lw = l; sub = s; ci = cin; sat = st; a = av; b = bv;
  endtask

  task automatic send();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] l, input logic s, input logic cin,
                     input logic st, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ec, input logic [15:0] eco, input int elat);
    set_in(l, s, cin, st, av, bv);
    send();
    chk({tag, "_busy_rdy"}, in_ready, 1'b0);
    wait_out(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_co"}, co_lanes, eco);
    handshake();
    chk({tag, "_idle_vld"}, out_valid, 1'b0);
  endtask

  initial begin
    g_reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    g_reset = 1'b0;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_c", c, 32'h0);
    chk("rst_co", co_lanes, 16'h0);

    run("t1", 3'd4, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 16'h0001, LAT);
    run("t2", 3'd2, 1'b0, 1'b0, 1'b0, 32'h01FF80FF, 32'h01018001, 32'h02000000, 16'h0007, LAT);
    run("t3", 3'd3, 1'b1, 1'b0, 1'b0, 32'h00050003, 32'h00020004, 32'h0003FFFF, 16'h0002, LAT);
    run("l2", 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h55555555, 32'h00000000, 16'hFFFF, LAT);
    run("ci", 3'd0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000001, 16'h0000, LAT);
    run("clmp", 3'd7, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 16'h0001, LAT);
    run("subci", 3'd4, 1'b1, 1'b1, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 16'h0001, LAT);

    // Output stall with a second request waiting.
    set_in(3'd2, 1'b0, 1'b0, 1'b0, 32'h01FF80FF, 32'h01018001);
    send();
    wait_out(lat);
    chk("t4_lat", lat, LAT);
    set_in(3'd3, 1'b1, 1'b0, 1'b0, 32'h00050003, 32'h00020004);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_c", c, 32'h02000000);
      chk("t4_hold_co", co_lanes, 16'h0007);
      chk("t4_hold_rdy", in_ready, 1'b0);
      chk("t4_hold_vld", out_valid, 1'b1);
    end
    handshake();
    chk("t4_hs_vld", out_valid, 1'b0);
    chk("t4_hs_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t4_acc_rdy", in_ready, 1'b0);
    wait_out(lat);
    chk("t4b_lat", lat, LAT);
    chk("t4b_c", c, 32'h0003FFFF);
    chk("t4b_co", co_lanes, 16'h0002);
    handshake();

    // Reset while beat 2 is in flight.
    set_in(3'd4, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
    send();
    tick(); tick();
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    chk("t5_vld", out_valid, 1'b0);
    chk("t5_rdy", in_ready, 1'b1);
    chk("t5_c", c, 32'h0);
    chk("t5_co", co_lanes, 16'h0);
    run("t5b", 3'd3, 1'b0, 1'b0, 1'b0, 32'h1234FFFF, 32'h11110001, 32'h23450000, 16'h0001, LAT);

`ifdef SCARV_COP_PALU_SAT_EN
    run("t6", 3'd2, 1'b0, 1'b0, 1'b1, 32'hF0000010, 32'h20000005, 32'hFF000015, 16'h0008, LAT);
    run("t6s", 3'd3, 1'b1, 1'b0, 1'b1, 32'h00050003, 32'h00020004, 32'h00030000, 16'h0002, LAT);
`else
    run("t6", 3'd2, 1'b0, 1'b0, 1'b1, 32'hF0000010, 32'h20000005, 32'h10000015, 16'h0008, LAT);
    run("t6s", 3'd3, 1'b1, 1'b0, 1'b1, 32'h00050003, 32'h00020004, 32'h0003FFFF, 16'h0002, LAT);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scarv_cop_palu_addsub_seq.md
Name: scarv_cop_palu_addsub_seq

Overview:
Parametrised, multi-cycle packed add/subtract unit for the SCARV COP packed ALU. Operands up to W bits are split into independent lanes of a selectable power-of-two width. The carry chain is broken at every lane boundary. The datapath processes CW bits per cycle, with the inter-chunk carry held in a register, which trades latency for area on wide operands. A valid/ready handshake on both sides lets the block stall the COP pipeline.

Parameters:
W, 32, total operand width in bits; power of two, at least 32.
CW, 8, bits processed per cycle; power of two, at least 2, divides W. NBEAT = W/CW.

Ports:
g_clk  in  1  clock; all state updates on the rising edge.
g_reset  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
a  in  W  left-hand operand.
b  in  W  right-hand operand.
lw  in  3  lane width code: lane width = 2^(lw+1) bits (0→2, 1→4, 2→8, 3→16, 4→32, 5→64, ...). Codes with 2^(lw+1) > W mean one full-W lane.
sub  in  1  0 = a+b; 1 = a−b, computed as a + ~b + 1 per lane.
ci  in  1  carry into lane 0 for add; ignored for sub.
sat  in  1  unsigned saturate request; used only with the optional feature.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
c  out  W  packed result.
co_lanes  out  W/2  bit k = carry out of lane k. For sub this is the not-borrow flag. Bits at or above the lane count are 0.

Behaviour:
- Reset: state IDLE, beat counter 0, chunk carry 0, c = 0, co_lanes = 0, out_valid = 0, in_ready = 1. A reset in any state, including mid-operation, aborts the operation. No partial result is ever presented.
- State IDLE:
  - in_ready = 1.
  - On in_valid: latch a, b, lw, sub, ci and sat; clear c and co_lanes; go to BUSY with beat = 0.
- State BUSY:
  - in_ready = 0.
  - Each cycle processes bits [beat*CW +: CW] and writes those bits of c.
  - For each bit i in the chunk, the carry in is:
    - if i = 0: ci (add) or 1 (sub);
    - else if i is a lane boundary (i mod lanewidth == 0): 0 (add) or 1 (sub);
    - otherwise the carry out of bit i−1, where bit beat*CW−1 is taken from the chunk-carry register.
  - The carry out of the top bit of each lane is written to co_lanes[lane].
  - The chunk carry register captures the carry out of the chunk's top bit, masked to 0 when the next bit starts a new lane.
  - When beat == NBEAT−1, go to DONE (or FIX with the optional feature); otherwise beat++.
- State DONE:
  - out_valid = 1; c and co_lanes are held stable.
  - When out_ready = 1: go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE; there is no same-cycle accept. The next request can be accepted in the cycle after the output handshake.
- Latency: request accepted at edge t → out_valid high after edge t+NBEAT (t+NBEAT+1 with the optional feature). Throughput is one result per NBEAT+2 cycles at best.
- Lanes narrower than CW complete several per beat. Lanes wider than CW span beats through the chunk carry register.
- Results are modulo 2^lanewidth per lane. No lane affects another lane's sum bits.
- If in_valid and out_ready are both high while in DONE, only the output handshake completes.

Optional Feature:
Macro SCARV_COP_PALU_SAT_EN.
- Defined: adds state FIX between BUSY and DONE, one cycle long. If the latched sat = 1, FIX replaces every lane whose co_lanes bit flags overflow:
  - add with co = 1 → lane becomes all ones;
  - sub with co = 0 (borrow) → lane becomes all zeros.
  co_lanes is left unchanged. If sat = 0, FIX passes the result through unchanged but still costs one cycle.
- Not defined: the sat input is ignored, FIX does not exist, and results always wrap.

Test Plan:
1. W=32, CW=8, lw=4, add, a=0xFFFFFFFF, b=0x00000001, ci=0 → c=0x00000000, co_lanes[0]=1, out_valid 4 cycles after accept.
2. lw=2, add, a=0x01FF80FF, b=0x01018001 → c=0x02000000, co_lanes[3:0]=4'b0111; no carry crosses any byte lane.
3. lw=3, sub, a=0x00050003, b=0x00020004 → c=0x0003FFFF, co_lanes[1:0]=2'b10.
4. Hold out_ready=0 for 3 cycles after out_valid → c and co_lanes stable, in_ready=0. A second request held on in_valid is accepted exactly one cycle after the out_valid/out_ready handshake.
5. Assert g_reset during beat 2 → next cycle out_valid=0, in_ready=1, c=0, co_lanes=0. A fresh request then completes correctly.
6. lw=2, add, sat=1, a=0xF0000010, b=0x20000005 → with SCARV_COP_PALU_SAT_EN: c=0xFF000015, latency 5 cycles. Without the macro: c=0x10000015, latency 4 cycles. co_lanes[3]=1 in both builds.
